flopr: RTL and testbench
========================

# flopr

Parameterized resettable D register: captures a WIDTH-bit data word on every rising clock edge and presents it on `q`. It is the basic state-holding element of the core datapath (PC register, pipeline boundaries, general state registers). An asynchronous active-low reset forces the stored word to a fixed reset value. An optional delay-line depth parameter lets one instance stand in for a chain of back-to-back registers.

## Interface
- `WIDTH`, default 32: data word width in bits; legal range 1..1024.
- `RESET_VALUE`, default all-zeros (WIDTH bits): value loaded into every stage while reset is asserted.
- `STAGES`, default 1: number of cascaded register stages (latency in cycles); legal range 1..16.
- `clk`  input  1  the only clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset; low clears all stages to RESET_VALUE immediately, independent of `clk`.
- `d`  input  WIDTH  data word to capture.
- `q`  output  WIDTH  registered data word, i.e. the output of the last stage.
- No other ports. No enable input and no clear input. Every port is required.

## Operation
- Each stage is a WIDTH-bit register.
  - Stage 0 loads `d` on every rising `clk` edge.
  - Stage k loads stage k-1 on every rising edge.
  - `q` is stage STAGES-1.
- Reset asserted (`reset` = 0):
  - All stages equal RESET_VALUE at once.
  - `q` = RESET_VALUE within the same delta cycle, with no clock required.
- While reset is held low, clock edges are ignored and all stages stay at RESET_VALUE.
- Reset deasserted (`reset` 0→1): the first rising edge strictly after deassertion loads normally.
- Reset asserted mid-operation discards all in-flight words. There is no partial flush.
- `d` is sampled only at rising edges. Changes to `d` between edges, including on falling edges, have no effect on `q`.
- `q` is never combinationally dependent on `d`.
- X or Z on `d` propagates as-is. The register does not sanitize data.
- Arithmetic: none. The data path is a pure bitwise copy; bit i of `d` maps to bit i of `q`.

## Timing
- Latency: `q` equals the `d` value sampled STAGES rising edges earlier.
  - With STAGES=1, `q` after edge n equals `d` as present just before edge n.
- Throughput: one new word accepted every cycle; no handshake, no stall.
- `q` changes only:
  - immediately after a rising `clk` edge while reset is high, or
  - immediately on the falling edge of `reset`.
- Reset release and a clock edge in the same time step: the edge does not load. The first load occurs on the next edge.
- Power-up without reset: contents are undefined (X in simulation). The system is required to reset before use.

## Structure
- Shared package `flopr_pkg`:
  - `FLOPR_DEFAULT_WIDTH` = 32
  - `FLOPR_MAX_STAGES` = 16
  - parameter-legality check helper.
- Sub-module `flopr_stage`: a single WIDTH-bit async-low-reset register.
  - Ports: `clk`, `reset`, `d`, `q`.
  - Parameters: WIDTH, RESET_VALUE.
- `flopr` instantiates STAGES copies of `flopr_stage` in a generate loop, chained `d`→`q`.
- Elaboration-time assertions reject WIDTH < 1 and STAGES outside 1..FLOPR_MAX_STAGES.
- Simulation-only assertions check:
  - `q` == RESET_VALUE whenever `reset` is low;
  - `q` is stable between rising edges while `reset` is high.

## Test plan
- Reset: WIDTH=32, STAGES=1. Drive `reset`=0 with `clk` idle and `d`=32'hDEADBEEF → `q`=32'h0 with no clock edge; holds 32'h0 across 3 edges while reset is low.
- Capture: reset high. Apply 10 random `d` words, updating `d` mid-cycle → after each rising edge, `q` equals the `d` present at that edge (e.g. `d`=32'h12345678 → `q`=32'h12345678).
- Hold: reset high. Toggle `d` between 32'hFFFFFFFF and 32'h0 on falling edges and between edges → `q` changes only at rising edges.
- Async reset mid-operation: `q`=32'hA5A5A5A5. Drop `reset` halfway through the clock high phase → `q`=32'h0 immediately. Release with `d`=32'h1 → `q`=32'h1 only after the next rising edge.
- Parameter variant: WIDTH=8, STAGES=3, RESET_VALUE=8'h5A.
  - During reset, `q`=8'h5A.
  - Feed 8'h01, 8'h02, 8'h03 on consecutive edges → `q` shows 8'h01 after the 3rd edge, 8'h02 after the 4th, 8'h03 after the 5th.

Source files
------------

// File: rtl/flopr_pkg.sv
// Shared constants and parameter-legality helper for the flopr register family.
package flopr_pkg;

   localparam int FLOPR_DEFAULT_WIDTH = 32;
   localparam int FLOPR_MAX_WIDTH     = 1024;
   localparam int FLOPR_MAX_STAGES    = 16;

   // True when the width/depth combination can be built.
   function automatic logic flopr_params_ok(input int width, input int stages);
      logic ok;
      ok = 1'b1;
      if ((width < 1) || (width > FLOPR_MAX_WIDTH)) begin
         ok = 1'b0;
      end else if ((stages < 1) || (stages > FLOPR_MAX_STAGES)) begin
         ok = 1'b0;
      end else begin
         ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/flopr_chk.sv
// Simulation-only property checks for flopr: reset value and inter-edge stability.
module flopr_chk #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input logic             clk,
   input logic             reset,
   input logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_mid_r;
   logic             mid_valid_r;

   // Mid-cycle sample of q, plus the reset-value check while reset is held low.
   always @(negedge clk) begin
      q_mid_r     <= q;
      mid_valid_r <= (reset === 1'b1);
      if (reset === 1'b0) begin
         assert (q === RESET_VALUE)
            else $error("flopr_chk: q=%h differs from reset value %h while reset low", q, RESET_VALUE);
      end
   end

   // Just before the stages update, q must still hold its mid-cycle value.
   always @(posedge clk) begin
      if (mid_valid_r && (reset === 1'b1)) begin
         assert (q === q_mid_r)
            else $error("flopr_chk: q moved between edges (%h -> %h)", q_mid_r, q);
      end
   end

endmodule

// File: rtl/flopr_stage.sv
// Single WIDTH-bit register with asynchronous active-low reset to RESET_VALUE.
module flopr_stage
   import flopr_pkg::*;
#(
   parameter int               WIDTH       = FLOPR_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_r;

   // Capture d on every rising edge; reset low forces RESET_VALUE without a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_r <= RESET_VALUE;
      end else begin
         data_r <= d;
      end
   end

   assign q = data_r;

endmodule

// File: rtl/flopr.sv
// Parameterized resettable D register; STAGES back-to-back copies form a delay line.
module flopr
   import flopr_pkg::*;
#(
   parameter int               WIDTH       = FLOPR_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
   parameter int               STAGES      = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Refuse to elaborate an unbuildable width/depth.
   if (!flopr_params_ok(WIDTH, STAGES)) begin : g_bad_params
      $error("flopr: illegal parameters WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
   end

   // chain_s[0] is the input word, chain_s[k+1] is the output of stage k.
   logic [WIDTH-1:0] chain_s [0:STAGES];

   assign chain_s[0] = d;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      flopr_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .clk   (clk),
         .reset (reset),
         .d     (chain_s[k]),
         .q     (chain_s[k+1])
      );
   end

   // q comes straight from the last stage, never from d.
   assign q = chain_s[STAGES];

`ifndef SYNTHESIS
   flopr_chk #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_chk (
      .clk   (clk),
      .reset (reset),
      .q     (q)
   );
`endif

endmodule

// File: tb/tb_flopr.sv
// Directed, table-driven bench for flopr: a default 32-bit single stage and an 8-bit three-stage variant.
module tb_flopr;

   logic        clk;
   logic        clk_en;
   logic        reset_a;
   logic        reset_b;
   logic [31:0] d_a;
   logic [31:0] q_a;
   logic [7:0]  d_b;
   logic [7:0]  q_b;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [31:0] d;
      logic [31:0] q_exp;
   } vec_t;

   vec_t vecs [10];

   flopr #(
      .WIDTH  (32),
      .STAGES (1)
   ) dut_a (
      .clk   (clk),
      .reset (reset_a),
      .d     (d_a),
      .q     (q_a)
   );

   flopr #(
      .WIDTH       (8),
      .RESET_VALUE (8'h5A),
      .STAGES      (3)
   ) dut_b (
      .clk   (clk),
      .reset (reset_b),
      .d     (d_b),
      .q     (q_b)
   );

   // Gated clock so the reset check can run with the clock idle.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Hard stop if the run ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "tb_flopr watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clk      = 1'b0;
      clk_en   = 1'b0;
      reset_a  = 1'b1;
      reset_b  = 1'b1;
      d_a      = 32'hDEADBEEF;
      d_b      = 8'h00;

      vecs[0] = '{32'h12345678, 32'h12345678};
      vecs[1] = '{32'h9ABCDEF0, 32'h9ABCDEF0};
      vecs[2] = '{32'h00000000, 32'h00000000};
      vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[4] = '{32'h80000001, 32'h80000001};
      vecs[5] = '{32'h55AA55AA, 32'h55AA55AA};
      vecs[6] = '{32'hCAFEF00D, 32'hCAFEF00D};
      vecs[7] = '{32'h00000001, 32'h00000001};
      vecs[8] = '{32'h7FFFFFFE, 32'h7FFFFFFE};
      vecs[9] = '{32'h3C3C3C3C, 32'h3C3C3C3C};

      // Reset with the clock idle: q must clear with no edge.
      #2;
      reset_a = 1'b0;
      reset_b = 1'b0;
      #1;
      check("reset_no_clk_a", q_a, 32'h00000000);
      check("reset_no_clk_b", {24'h0, q_b}, 32'h0000005A);

      // Edges while reset is low are ignored.
      clk_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_hold_a", q_a, 32'h00000000);
         check("reset_hold_b", {24'h0, q_b}, 32'h0000005A);
      end

      // Release away from an edge; the next rising edge loads.
      @(negedge clk);
      reset_a = 1'b1;
      #1;
      check("release_no_load", q_a, 32'h00000000);
      @(posedge clk);
      #1;
      check("first_load", q_a, 32'hDEADBEEF);

      // Capture table: d set at falling edge, disturbed mid high phase.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         d_a = vecs[i].d;
         @(posedge clk);
         #1;
         check("capture", q_a, vecs[i].q_exp);
         #2;
         d_a = 32'h0BAD0BAD;
         #1;
         check("capture_hold", q_a, vecs[i].q_exp);
      end

      // Hold: d toggles on falling edges and between edges.
      @(negedge clk);
      d_a = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      check("hold_ones", q_a, 32'hFFFFFFFF);
      d_a = 32'h00000000;
      #2;
      check("hold_mid", q_a, 32'hFFFFFFFF);
      @(negedge clk);
      #1;
      check("hold_falling", q_a, 32'hFFFFFFFF);
      d_a = 32'hFFFFFFFF;
      #1;
      d_a = 32'h00000000;
      @(posedge clk);
      #1;
      check("hold_zero", q_a, 32'h00000000);

      // Async reset in the high phase, release with d=1.
      @(negedge clk);
      d_a = 32'hA5A5A5A5;
      @(posedge clk);
      #1;
      check("pre_reset", q_a, 32'hA5A5A5A5);
      #1;
      reset_a = 1'b0;
      d_a     = 32'h00000001;
      #1;
      check("async_reset", q_a, 32'h00000000);
      @(negedge clk);
      reset_a = 1'b1;
      #1;
      check("after_release", q_a, 32'h00000000);
      @(posedge clk);
      #1;
      check("load_after_release", q_a, 32'h00000001);

      // Three-stage variant: reset value flushes out, then 01/02/03 follow.
      @(negedge clk);
      reset_b = 1'b1;
      d_b     = 8'h01;
      #1;
      check("b_release", {24'h0, q_b}, 32'h0000005A);
      @(posedge clk);
      #1;
      check("b_edge1", {24'h0, q_b}, 32'h0000005A);
      @(negedge clk);
      d_b = 8'h02;
      @(posedge clk);
      #1;
      check("b_edge2", {24'h0, q_b}, 32'h0000005A);
      @(negedge clk);
      d_b = 8'h03;
      @(posedge clk);
      #1;
      check("b_edge3", {24'h0, q_b}, 32'h00000001);
      @(negedge clk);
      d_b = 8'h04;
      @(posedge clk);
      #1;
      check("b_edge4", {24'h0, q_b}, 32'h00000002);
      @(negedge clk);
      d_b = 8'h05;
      @(posedge clk);
      #1;
      check("b_edge5", {24'h0, q_b}, 32'h00000003);

      // Mid-flight reset discards all in-flight words in the chain.
      #1;
      reset_b = 1'b0;
      #1;
      check("b_async_reset", {24'h0, q_b}, 32'h0000005A);
      @(negedge clk);
      reset_b = 1'b1;
      d_b     = 8'h77;
      @(posedge clk);
      #1;
      check("b_flush1", {24'h0, q_b}, 32'h0000005A);
      @(posedge clk);
      #1;
      check("b_flush2", {24'h0, q_b}, 32'h0000005A);
      @(posedge clk);
      #1;
      check("b_refill", {24'h0, q_b}, 32'h00000077);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
